// File: rtl/pll_cfg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pll_cfg_pkg
// Description : Shared types and constants for the PLL reconfiguration
//               sequencer: FSM states, controller register map and the
//               write-list entry layout.
// Revision    : 1.0 - initial release
// ============================================================================
package pll_cfg_pkg;

  // Sequencer states; WAIT_UNLOCK/WAIT_LOCK split the lock wait in two halves
  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_WR          = 3'd1,
    S_RD          = 3'd2,
    S_WAIT_UNLOCK = 3'd3,
    S_WAIT_LOCK   = 3'd4,
    S_DONE        = 3'd5
  } state_t;

  // Dynamic-reconfig controller register map
  localparam logic [5:0] ADDR_MODE  = 6'h00;
  localparam logic [5:0] ADDR_START = 6'h02;
  localparam logic [5:0] ADDR_M     = 6'h04;
  localparam logic [5:0] ADDR_C     = 6'h05;
  localparam logic [5:0] ADDR_K     = 6'h07;

  // Index of the final (start) entry in the write list
  localparam logic [2:0] LAST_IDX = 3'd4;

  typedef struct packed {
    logic [5:0]  addr;
    logic [31:0] data;
  } wr_entry_t;

endpackage
`default_nettype wire

// File: rtl/pll_cfg_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : pll_cfg_seq_if
// Description : Avalon-MM management port of the PLL reconfig controller.
//               master = sequencer side, slave = controller side.
// Revision    : 1.0 - initial release
// ============================================================================
interface pll_cfg_seq_if;
  logic [5:0]  address;
  logic        write;
  logic [31:0] writedata;
  logic        read;
  logic [31:0] readdata;
  logic        waitrequest;

  modport master (
    output address, write, writedata, read,
    input  readdata, waitrequest
  );

  modport slave (
    input  address, write, writedata, read,
    output readdata, waitrequest
  );
endinterface
`default_nettype wire

// File: rtl/pll_cfg_sync.sv
`default_nettype none
// ============================================================================
// Module      : pll_cfg_sync
// Description : Two-flop synchronizer for a single asynchronous level.
// Revision    : 1.0 - initial release
// ============================================================================
module pll_cfg_sync (
  input  wire logic clk,
  input  wire logic rst_n,
  input  wire logic d,
  output logic      q
);
  logic meta;

  // Two-stage capture of the asynchronous input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule
`default_nettype wire

// File: rtl/pll_cfg_seq.sv
`default_nettype none
// ============================================================================
// Module      : pll_cfg_seq
// Description : Video PLL reconfiguration sequencer. When the selected
//               profile differs from the applied one (or on a force pulse)
//               it writes MODE, M, K, C0 and START over the Avalon-MM
//               management port, then waits for the PLL to lose and regain
//               lock, with a cycle timeout.
//               Build option: PLL_CFG_READBACK_EN - read back M, K and C0
//               after each write and abort the sequence on a mismatch.
// Revision    : 1.0 - initial release
// ============================================================================
module pll_cfg_seq
  import pll_cfg_pkg::*;
#(
  parameter logic [31:0] PROF0_M      = 32'h0002_0504,
  parameter logic [31:0] PROF0_K      = 32'h147E_6739,
  parameter logic [31:0] PROF0_C0     = 32'h0000_0404,
  parameter logic [31:0] PROF1_M      = 32'h0002_0504,
  parameter logic [31:0] PROF1_K      = 32'd702807832,
  parameter logic [31:0] PROF1_C0     = 32'h0000_0404,
  parameter logic [23:0] LOCK_TIMEOUT = 24'd5_000_000
) (
  input  wire logic      refclk,
  input  wire logic      rst_n,
  input  wire logic      sel,
  // "force" is a reserved word, hence the suffix
  input  wire logic      force_req,
  input  wire logic      pll_locked,
  output logic           busy,
  output logic           done,
  output logic           err,
  pll_cfg_seq_if.master  mgmt
);

  logic        sel_s, lock_s;
  state_t      state, state_n;
  logic [2:0]  idx, idx_n;
  logic        prof, prof_n;
  logic        applied, applied_n;
  logic        err_n;
  logic [23:0] cnt, cnt_n;
  logic        wr_q, wr_n;
  logic        rd_q, rd_n;
  logic [5:0]  addr_q, addr_n;
  logic [31:0] data_q, data_n;
  wr_entry_t   cur, nxt;

  pll_cfg_sync u_sync_sel  (.clk(refclk), .rst_n(rst_n), .d(sel),        .q(sel_s));
  pll_cfg_sync u_sync_lock (.clk(refclk), .rst_n(rst_n), .d(pll_locked), .q(lock_s));

  // Write list for profile p, entry i
  function automatic wr_entry_t list_entry(input logic p, input logic [2:0] i);
    wr_entry_t e;
    case (i)
      3'd0:    begin e.addr = ADDR_MODE;  e.data = 32'd0;                   end
      3'd1:    begin e.addr = ADDR_M;     e.data = p ? PROF1_M  : PROF0_M;  end
      3'd2:    begin e.addr = ADDR_K;     e.data = p ? PROF1_K  : PROF0_K;  end
      3'd3:    begin e.addr = ADDR_C;     e.data = p ? PROF1_C0 : PROF0_C0; end
      default: begin e.addr = ADDR_START; e.data = 32'd1;                   end
    endcase
    return e;
  endfunction

  assign cur = list_entry(prof, idx);
  assign nxt = list_entry(prof, idx + 3'd1);

  // State and registered bus outputs
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      idx     <= 3'd0;
      prof    <= 1'b0;
      applied <= 1'b0;
      err     <= 1'b0;
      cnt     <= 24'd0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      addr_q  <= 6'd0;
      data_q  <= 32'd0;
    end else begin
      state   <= state_n;
      idx     <= idx_n;
      prof    <= prof_n;
      applied <= applied_n;
      err     <= err_n;
      cnt     <= cnt_n;
      wr_q    <= wr_n;
      rd_q    <= rd_n;
      addr_q  <= addr_n;
      data_q  <= data_n;
    end
  end

  // Next-state logic; bus signals hold their value unless a transfer completes
  always_comb begin
    state_n   = state;
    idx_n     = idx;
    prof_n    = prof;
    applied_n = applied;
    err_n     = err;
    cnt_n     = cnt;
    wr_n      = wr_q;
    rd_n      = rd_q;
    addr_n    = addr_q;
    data_n    = data_q;

    case (state)
      S_IDLE: begin
        if ((sel_s != applied) || force_req) begin
          state_n = S_WR;
          prof_n  = sel_s;
          err_n   = 1'b0;
          idx_n   = 3'd0;
          wr_n    = 1'b1;
          addr_n  = ADDR_MODE;
          data_n  = 32'd0;
        end
      end

      S_WR: begin
        if (!mgmt.waitrequest) begin
          wr_n = 1'b0;
          if (idx == LAST_IDX) begin
            state_n = S_WAIT_UNLOCK;
            cnt_n   = LOCK_TIMEOUT;
          end
`ifdef PLL_CFG_READBACK_EN
          else if (idx != 3'd0) begin
            // Read back the register just written, same address
            state_n = S_RD;
            rd_n    = 1'b1;
          end
`endif
          else begin
            idx_n  = idx + 3'd1;
            wr_n   = 1'b1;
            addr_n = nxt.addr;
            data_n = nxt.data;
          end
        end
      end

      S_RD: begin
        if (!mgmt.waitrequest) begin
          rd_n = 1'b0;
          if (mgmt.readdata != cur.data) begin
            // Abort: never start the PLL on a mis-programmed register
            err_n   = 1'b1;
            state_n = S_DONE;
          end else begin
            state_n = S_WR;
            idx_n   = idx + 3'd1;
            wr_n    = 1'b1;
            addr_n  = nxt.addr;
            data_n  = nxt.data;
          end
        end
      end

      S_WAIT_UNLOCK, S_WAIT_LOCK: begin
        // One timeout budget covers both the unlock and the relock phases
        cnt_n = cnt - 24'd1;
        if (state == S_WAIT_LOCK && lock_s) begin
          state_n = S_DONE;
        end else if (cnt <= 24'd1) begin
          err_n   = 1'b1;
          state_n = S_DONE;
        end else if (state == S_WAIT_UNLOCK && !lock_s) begin
          state_n = S_WAIT_LOCK;
        end
      end

      S_DONE: begin
        applied_n = prof;
        state_n   = S_IDLE;
      end

      default: state_n = S_IDLE;
    endcase
  end

  assign busy = (state == S_WR) || (state == S_RD) ||
                (state == S_WAIT_UNLOCK) || (state == S_WAIT_LOCK);
  assign done = (state == S_DONE);

  assign mgmt.address   = addr_q;
  assign mgmt.write     = wr_q;
  assign mgmt.writedata = data_q;
`ifdef PLL_CFG_READBACK_EN
  assign mgmt.read      = rd_q;
`else
  assign mgmt.read      = 1'b0;
`endif

endmodule
`default_nettype wire
